// File: rtl/route_sequencer.sv
// Route sequencer: queues Zigbee route commands and steps the line-follow manoeuvres.
// Define ROUTE_LOST_LINE_EN to add lost-line recovery (LOST state and lost_line port).
module route_sequencer #(
    parameter int unsigned CMD_W          = 3,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMER_W        = 27,
    parameter int unsigned FWD_CYCLES     = 25000000,
    parameter int unsigned ST_FWD_CYCLES  = 30000000,
    parameter int unsigned ST_BACK_CYCLES = 30000000,
    parameter int unsigned COMM_TIMEOUT   = 50000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sensor_l,
    input  logic                        sensor_m,
    input  logic                        sensor_r,
    input  logic [CMD_W-1:0]            cmd_in,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic                        start_communication,
    output logic                        comm_error,
    output logic [2:0]                  output_action,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
`ifdef ROUTE_LOST_LINE_EN
    ,
    output logic                        lost_line
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [TIMER_W-1:0] T_FWD_END  = TIMER_W'(FWD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_STF_END  = TIMER_W'(ST_FWD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_STB_END  = TIMER_W'(ST_BACK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_COMM_END = TIMER_W'(COMM_TIMEOUT - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_REQ, S_REQ_GAP, S_DECIDE,
        S_F0, S_F1, S_F2, S_F3,
        S_L0, S_L1, S_R0, S_R1, S_U0, S_U1,
        S_BK, S_S0, S_S1
`ifdef ROUTE_LOST_LINE_EN
        , S_LOST
`endif
    } state_t;

    state_t             r_state, w_next;
    logic [TIMER_W-1:0] r_timer;
    logic [CMD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic [CMD_W-1:0]   r_cmd;
    logic [2:0]         w_sensor;
    logic               w_full, w_push, w_pop, w_flush, w_cmd_ok;

    assign w_sensor  = {sensor_l, sensor_m, sensor_r};
    assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && (r_level != '0);
    assign w_cmd_ok  = ((r_cmd >> 3) == '0);
    assign cmd_ready  = !w_full;
    assign fifo_level = r_level;

`ifdef ROUTE_LOST_LINE_EN
    localparam int unsigned LOST_CYCLES = 1000000;
    localparam int unsigned LOST_W      = $clog2(LOST_CYCLES);
    logic [LOST_W-1:0] r_lost_cnt;
    logic              w_lost_zone, w_lost_trip;

    assign w_lost_zone = (r_state inside {S_F0, S_F1, S_F2, S_F3, S_S0}) && (w_sensor == 3'b111);
    assign w_lost_trip = w_lost_zone && (r_lost_cnt == LOST_W'(LOST_CYCLES - 1));
    assign w_flush     = (r_state == S_LOST);
    assign lost_line   = (r_state == S_LOST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          r_lost_cnt <= '0;
        else if (w_lost_zone && !w_lost_trip) r_lost_cnt <= r_lost_cnt + 1'b1;
        else                                 r_lost_cnt <= '0;
    end
`else
    assign w_flush = 1'b0;
`endif

    // Full is taken from the registered level, so a push is refused even when a pop frees a slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_cmd    <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cmd    <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= cmd_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)  r_timer <= '0;
            else if (r_timer != '1) r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        w_next              = r_state;
        output_action       = 3'b011;
        start_communication = 1'b0;
        comm_error          = 1'b0;
        busy                = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy   = 1'b0;
                w_next = (r_level != '0) ? S_DECIDE : S_REQ;
            end
            S_REQ: begin
                busy                = 1'b0;
                start_communication = 1'b1;
                if (r_level != '0)            w_next = S_IDLE;
                else if (r_timer == T_COMM_END) w_next = S_REQ_GAP;
            end
            S_REQ_GAP: begin
                busy       = 1'b0;
                comm_error = 1'b1;
                w_next     = S_REQ;
            end
            S_DECIDE: begin
                w_next = S_IDLE;
                if (w_cmd_ok) begin
                    case (r_cmd[2:0])
                        3'b001:  w_next = S_F0;
                        3'b011:  w_next = S_L0;
                        3'b010:  w_next = S_R0;
                        3'b100:  w_next = S_U0;
                        3'b101:  w_next = S_BK;
                        3'b110:  w_next = S_F2;
                        3'b111:  w_next = S_S0;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_F0: begin output_action = 3'b000; if (w_sensor == 3'b000) w_next = S_F1; end
            S_F1: begin output_action = 3'b000; if (w_sensor == 3'b101) w_next = S_F2; end
            S_F2: begin output_action = 3'b000; if (w_sensor == 3'b000) w_next = S_F3; end
            S_F3: begin output_action = 3'b000; if (r_timer == T_FWD_END) w_next = S_IDLE; end
            S_L0: begin output_action = 3'b001; if (w_sensor == 3'b111) w_next = S_L1; end
            S_L1: begin output_action = 3'b001; if (w_sensor == 3'b101) w_next = S_IDLE; end
            S_R0: begin output_action = 3'b010; if (w_sensor == 3'b111) w_next = S_R1; end
            S_R1: begin output_action = 3'b010; if (w_sensor == 3'b101) w_next = S_IDLE; end
            S_U0: begin output_action = 3'b010; if (w_sensor == 3'b111) w_next = S_U1; end
            S_U1: begin output_action = 3'b010; if (w_sensor == 3'b101) w_next = S_R0; end
            S_BK: begin output_action = 3'b100; if (w_sensor == 3'b111) w_next = S_IDLE; end
            S_S0: begin output_action = 3'b000; if (r_timer == T_STF_END) w_next = S_S1; end
            S_S1: begin output_action = 3'b100; if (r_timer == T_STB_END) w_next = S_IDLE; end
`ifdef ROUTE_LOST_LINE_EN
            S_LOST: w_next = S_REQ;
`endif
            default: w_next = S_IDLE;
        endcase
`ifdef ROUTE_LOST_LINE_EN
        if (w_lost_trip) w_next = S_LOST;
`endif
    end
endmodule

// File: doc/route_sequencer.md
Name: route_sequencer

Overview:
- Parametrised successor to the top-level drive controller: sequences line-follow manoeuvres from a buffered queue of route commands received over the Zigbee link.
- Commands are queued in a FIFO, so the robot only stops to request instructions when the queue is empty.
- Adds an internal manoeuvre timer, a communication timeout with retry, and programmable manoeuvre durations.
- Sits between the Zigbee receiver and the motor/line-follow action decoder.

Parameters:
- CMD_W, 3, command code width; only the low 3 bits are decoded, upper bits must be 0 or the command is invalid.
- FIFO_DEPTH, 4, command queue depth; power of 2, ≥2.
- TIMER_W, 27, internal timer width.
- FWD_CYCLES, 25000000, duration of forward_3 in clocks.
- ST_FWD_CYCLES, 30000000, station approach duration.
- ST_BACK_CYCLES, 30000000, station reverse duration.
- COMM_TIMEOUT, 50000000, clocks in REQ before a retry.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- sensor_l, sensor_m, sensor_r  in  1 each  line sensors; 0 = line; sensor = {l,m,r}.
- cmd_in  in  CMD_W  command from the Zigbee receiver.
- cmd_valid  in  1  cmd_in valid.
- cmd_ready  out  1  = FIFO not full.
- start_communication  out  1  request for next instruction(s).
- comm_error  out  1  one-cycle pulse on each timeout.
- output_action  out  3  000 follow_line, 001 turn_left, 010 turn_right, 011 do_nothing, 100 backward.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued commands.
- busy  out  1  high in any manoeuvre state.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, timer 0.
  - Output values in reset: output_action=011, start_communication=0, comm_error=0, busy=0, cmd_ready=1, fifo_level=0.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop occurs only in IDLE when not empty.
  - Simultaneous push+pop when full: the push is refused, because cmd_ready uses the registered full flag. The pop proceeds and fifo_level drops by 1.
  - Simultaneous push+pop otherwise: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Timer:
  - Clears on every state transition and increments each cycle otherwise.
  - Saturates at all-ones.
  - A timed state of N cycles exits when timer == N-1, so it is held exactly N cycles.
- IDLE:
  - Queue empty: go to REQ.
  - Queue not empty: pop the head into a command register and go to DECIDE.
  - output_action=011.
- REQ:
  - start_communication=1.
  - Leave for IDLE the cycle after fifo_level becomes nonzero.
  - If the timer reaches COMM_TIMEOUT-1: pulse comm_error, drive start_communication=0 for one cycle (state REQ_GAP), then return to REQ.
- DECIDE (1 cycle), code to next state:
  - 001 → F0.
  - 011 → L0.
  - 010 → R0.
  - 100 → U0.
  - 101 → BK.
  - 110 → F2.
  - 111 → S0.
  - 000 or nonzero upper bits → IDLE (command discarded).
- Forward sequence (output_action=000):
  - F0: sensor==000 → F1.
  - F1: sensor==101 → F2.
  - F2: sensor==000 → F3.
  - F3: exits after FWD_CYCLES → IDLE.
- Left turn (output_action=001): L0 waits for sensor==111 → L1; L1 waits for sensor==101 → IDLE.
- Right turn (output_action=010): R0 waits for sensor==111 → R1; R1 waits for sensor==101 → IDLE.
- U-turn (output_action=010): U0 waits for sensor==111 → U1; U1 waits for sensor==101 → R0.
- BK: output_action=100; sensor==111 → IDLE.
- Station visit:
  - S0: output_action=000 for ST_FWD_CYCLES → S1.
  - S1: output_action=100 for ST_BACK_CYCLES → IDLE.
- busy=1 in all states except IDLE, REQ and REQ_GAP.
- Commands may be pushed in any state, including mid-manoeuvre.
- Reset mid-manoeuvre flushes the FIFO.

Optional Feature:
- Macro: ROUTE_LOST_LINE_EN.
- Defined:
  - In F0–F3 and S0, LOST_CYCLES consecutive cycles (localparam 1000000) of sensor==111 force state LOST.
  - LOST: output_action=011, FIFO flushed, and a one-cycle lost_line output pulse on entry; next cycle → REQ.
  - The consecutive counter clears whenever sensor!=111.
- Undefined: no LOST state, no lost_line port, behaviour as above.

Test Plan:
- Parameters for the bench: FIFO_DEPTH=4, FWD_CYCLES=10, ST_FWD_CYCLES=5, ST_BACK_CYCLES=5, COMM_TIMEOUT=20.
- Reset low, then release with no commands → IDLE 1 cycle, then start_communication=1. After 20 cycles: comm_error pulse, start_communication=0 for 1 cycle, then 1 again.
- Push 001 with sensors 000, 101, 000 → output_action=000; F3 lasts exactly 10 cycles, then IDLE → REQ.
- Push 011, 010, 111, 110 back-to-back:
  - Expect fifo_level=4 and cmd_ready=0; a 5th push is ignored.
  - Manoeuvres then execute in order: left, right, station (5 cycles 000, 5 cycles 100), F2.
  - No start_communication until the queue drains.
- Push 100 with sensor 111, 101, 111, 101 → output_action=010 throughout, passing through states U0, U1, R0, R1, then IDLE.
- Push 000 and 1xx with nonzero upper bits (CMD_W=4) → each discarded within 2 cycles, output_action stays 011.
- Assert reset during S0 with 2 queued → all outputs immediately at reset values; after release, fifo_level=0 and start_communication=1.
